// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump path: index width, data width
// and the dump sequencer state encoding.
package regfile_dump_reader_pkg;

    localparam int REG_INDEX_W = 5;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through one register-file read port once
// the core has halted, emitting each as an {index, data} beat with a running
// XOR checksum and a one-cycle done pulse after the final beat is accepted.
//
// Stream handshake: a beat transfers on any rising edge where out_valid and
// out_ready are both high. Once raised, out_valid and every beat field hold
// until that transfer; the only exception is halted dropping (or reset), which
// withdraws the beat and returns the block to IDLE.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halted,
    output logic [REG_INDEX_W-1:0] rd_index,
    input  logic [DATA_W-1:0]      rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REG_INDEX_W-1:0] out_index,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      checksum
);

    localparam logic [REG_INDEX_W-1:0] FIRST_IDX = REG_INDEX_W'(FIRST_REG);
    localparam logic [REG_INDEX_W-1:0] LAST_IDX  = REG_INDEX_W'(LAST_REG);

    // Sequencer state; kept as a named signal so checkers can bind to it.
    dump_state_t state;
    dump_state_t state_next;

    logic [REG_INDEX_W-1:0] cur;
    logic                   launch;     // accepted start: reload cur, clear checksum
    logic                   load_beat;  // capture read-port data into the beat register
    logic                   accept;     // beat handshake this cycle
    logic                   advance;    // step cur to the next register

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; halted low in READ/OUT aborts to IDLE.
    always_comb begin
        state_next = state;
        rd_index   = '0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        launch     = 1'b0;
        load_beat  = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start && halted) begin
                    launch     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                rd_index = cur;
                busy     = 1'b1;
                if (!halted) begin
                    state_next = IDLE;
                end else begin
                    load_beat  = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // A transfer the consumer completes still counts toward the checksum.
                accept    = out_ready;
                if (!halted) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Register cursor, beat register and checksum accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            out_index <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            checksum  <= '0;
        end else begin
            if (launch) begin
                cur      <= FIRST_IDX;
                checksum <= '0;
            end
            if (load_beat) begin
                out_data  <= rd_data;
                out_index <= cur;
                out_last  <= (cur == LAST_IDX);
            end
            if (accept) begin
                checksum <= checksum ^ out_data;
            end
            if (advance) begin
                cur <= cur + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a default-range instance and a
// FIRST_REG=2..LAST_REG=3 instance share a modelled register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, halted, out_ready;
    logic [4:0]  rd_index;
    logic [31:0] rd_data;
    logic        out_valid;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        out_last, busy, done;
    logic [31:0] checksum;

    logic        start2, halted2, out_ready2;
    logic [4:0]  rd_index2;
    logic [31:0] rd_data2;
    logic        out_valid2;
    logic [4:0]  out_index2;
    logic [31:0] out_data2;
    logic        out_last2, busy2, done2;
    logic [31:0] checksum2;

    logic [31:0] regs [32];

    int          vectors = 0;
    int          miscompares = 0;
    logic [37:0] exp_q[$];      // {last, index, data}
    logic [31:0] exp_csum;
    int          done_count;

    // Clock / reset / register-file model.
    always #5 clk = ~clk;

    assign rd_data  = regs[rd_index];
    assign rd_data2 = regs[rd_index2];

    regfile_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halted    (halted),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(3)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .halted    (halted2),
        .rd_index  (rd_index2),
        .rd_data   (rd_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_index (out_index2),
        .out_data  (out_data2),
        .out_last  (out_last2),
        .busy      (busy2),
        .done      (done2),
        .checksum  (checksum2)
    );

    // Scoreboard: every accepted beat of dut is popped against the expected queue.
    always @(negedge clk) begin
        logic [37:0] beat_exp;
        #2;
        if (!reset && done) done_count++;
        if (!reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_extra: got idx=%0d data=%h, expected no beat", out_index, out_data);
            end else begin
                beat_exp = exp_q.pop_front();
                exp_csum ^= beat_exp[31:0];
                if ({out_last, out_index, out_data} !== beat_exp) begin
                    miscompares++;
                    $display("FAIL beat: got last=%0b idx=%0d data=%h, expected last=%0b idx=%0d data=%h",
                             out_last, out_index, out_data, beat_exp[37], beat_exp[36:32], beat_exp[31:0]);
                end
            end
        end
    end

    // Hard stop if the run wanders off.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_regs();
        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    endtask

    task automatic push_full();
        exp_q.delete();
        exp_csum = '0;
        for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), 5'(i), regs[i]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; halted = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; halted2 = 1'b0; out_ready2 = 1'b0;
        init_regs();
        repeat (3) @(negedge clk);
        vectors++;
        if ({rd_index, out_valid, out_index, out_data, out_last, busy, done, checksum} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd=%0d v=%0b idx=%0d data=%h last=%0b busy=%0b done=%0b cs=%h, expected all 0",
                     rd_index, out_valid, out_index, out_data, out_last, busy, done, checksum);
        end
        vectors++;
        if ({rd_index2, out_valid2, out_index2, out_data2, out_last2, busy2, done2, checksum2} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs2: got nonzero output, expected all 0");
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        int cyc;
        bit seen;
        init_regs();
        push_full();
        halted = 1'b1; out_ready = 1'b1; done_count = 0;
        pulse_start();
        vectors++;
        if ({busy, out_valid, rd_index} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL full_read_cycle: got busy=%0b valid=%0b rd=%0d, expected 1 0 0", busy, out_valid, rd_index);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, out_index, out_data} !== {1'b1, 5'd0, 32'h0}) begin
            miscompares++;
            $display("FAIL full_latency: got valid=%0b idx=%0d data=%h, expected 1 0 0", out_valid, out_index, out_data);
        end
        cyc = 2; seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            if (done) seen = 1;
        end
        vectors++;
        if (!seen || cyc != 65) begin
            miscompares++;
            $display("FAIL full_done_cycle: got seen=%0b cycle=%0d, expected done at cycle 65", seen, cyc);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_beats: got %0d beats missing, expected 0", exp_q.size());
        end
        vectors++;
        if (checksum !== 32'h1000_0000) begin
            miscompares++;
            $display("FAIL full_checksum: got %h, expected 10000000", checksum);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, out_valid} !== 3'b000 || done_count != 1) begin
            miscompares++;
            $display("FAIL full_done_pulse: got done=%0b busy=%0b valid=%0b pulses=%0d, expected 0 0 0 1",
                     done, busy, out_valid, done_count);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit seen, stalled;
        init_regs();
        push_full();
        halted = 1'b1; out_ready = 1'b1;
        pulse_start();
        cyc = 1; seen = 0; stalled = 0;
        while (!seen && cyc < 300) begin
            @(negedge clk); cyc++;
            if (done) seen = 1;
            if (!stalled && out_valid && out_index == 5'd7) begin
                stalled = 1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk); cyc++;
                    vectors++;
                    if ({out_valid, out_index, out_data} !== {1'b1, 5'd7, 32'h1000_0007}) begin
                        miscompares++;
                        $display("FAIL bp_hold: got valid=%0b idx=%0d data=%h, expected 1 7 10000007",
                                 out_valid, out_index, out_data);
                    end
                end
                out_ready = 1'b1;
            end
        end
        vectors++;
        if (!seen || !stalled || cyc != 70) begin
            miscompares++;
            $display("FAIL bp_done_cycle: got seen=%0b stalled=%0b cycle=%0d, expected done at cycle 70", seen, stalled, cyc);
        end
        vectors++;
        if (exp_q.size() != 0 || checksum !== exp_csum) begin
            miscompares++;
            $display("FAIL bp_checksum: got cs=%h left=%0d, expected cs=%h left=0", checksum, exp_q.size(), exp_csum);
        end
        @(negedge clk);
    endtask

    task automatic test_start_gating();
        int cyc;
        bit seen, poked;
        halted = 1'b0; out_ready = 1'b1;
        pulse_start();
        repeat (2) begin
            vectors++;
            if ({busy, out_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL gate_not_halted: got busy=%0b valid=%0b, expected 0 0", busy, out_valid);
            end
            @(negedge clk);
        end
        init_regs();
        push_full();
        halted = 1'b1;
        pulse_start();
        cyc = 1; seen = 0; poked = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (!poked && out_valid && out_index == 5'd5) begin
                start = 1'b1;
                poked = 1;
            end
            if (done) begin
                seen = 1;
                start = 1'b1;   // start while in DONE
            end
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (!seen || cyc != 65 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL gate_restart: got seen=%0b cycle=%0d left=%0d, expected done at 65 with 0 left",
                     seen, cyc, exp_q.size());
        end
        vectors++;
        if ({busy, out_valid} !== 2'b00 || checksum !== exp_csum) begin
            miscompares++;
            $display("FAIL gate_done_start: got busy=%0b valid=%0b cs=%h, expected 0 0 cs=%h",
                     busy, out_valid, checksum, exp_csum);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int cyc;
        bit hit;
        init_regs();
        exp_q.delete();
        exp_csum = '0;
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, 5'(i), regs[i]});
        halted = 1'b1; out_ready = 1'b1; done_count = 0;
        pulse_start();
        cyc = 1; hit = 0;
        while (!hit && cyc < 200) begin
            @(negedge clk); cyc++;
            if (out_valid && out_index == 5'd12) begin
                hit = 1;
                out_ready = 1'b0;
                halted = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (!hit || {out_valid, busy, done, rd_index} !== 8'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got hit=%0b valid=%0b busy=%0b done=%0b rd=%0d, expected 1 0 0 0 0",
                     hit, out_valid, busy, done, rd_index);
        end
        vectors++;
        if (checksum !== exp_csum || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_checksum: got cs=%h left=%0d, expected cs=%h left=0", checksum, exp_q.size(), exp_csum);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (done_count != 0 || checksum !== exp_csum) begin
            miscompares++;
            $display("FAIL abort_no_done: got pulses=%0d cs=%h, expected 0 cs=%h", done_count, checksum, exp_csum);
        end
        halted = 1'b1; out_ready = 1'b1;
    endtask

    task automatic test_param_range();
        logic [37:0] q2[$];
        logic [37:0] e;
        int cyc, beats;
        bit seen;
        init_regs();
        regs[2] = 32'hDEAD_BEEF;
        regs[3] = 32'h0000_FFFF;
        q2.push_back({1'b0, 5'd2, 32'hDEAD_BEEF});
        q2.push_back({1'b1, 5'd3, 32'h0000_FFFF});
        halted2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        vectors++;
        if ({busy2, rd_index2} !== {1'b1, 5'd2}) begin
            miscompares++;
            $display("FAIL param_first: got busy=%0b rd=%0d, expected 1 2", busy2, rd_index2);
        end
        cyc = 1; beats = 0; seen = 0;
        while (!seen && cyc < 50) begin
            @(negedge clk); cyc++;
            if (out_valid2) begin
                beats++;
                vectors++;
                if (q2.size() == 0) begin
                    miscompares++;
                    $display("FAIL param_extra: got idx=%0d, expected no beat", out_index2);
                end else begin
                    e = q2.pop_front();
                    if ({out_last2, out_index2, out_data2} !== e) begin
                        miscompares++;
                        $display("FAIL param_beat: got last=%0b idx=%0d data=%h, expected last=%0b idx=%0d data=%h",
                                 out_last2, out_index2, out_data2, e[37], e[36:32], e[31:0]);
                    end
                end
            end
            if (done2) seen = 1;
        end
        vectors++;
        if (!seen || beats != 2 || cyc != 5) begin
            miscompares++;
            $display("FAIL param_done: got seen=%0b beats=%0d cycle=%0d, expected 1 2 5", seen, beats, cyc);
        end
        vectors++;
        if (checksum2 !== 32'hDEAD_4110) begin
            miscompares++;
            $display("FAIL param_checksum: got %h, expected dead4110", checksum2);
        end
        halted2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        bit hit, seen;
        init_regs();
        push_full();
        halted = 1'b1; out_ready = 1'b1; done_count = 0;
        pulse_start();
        cyc = 1; hit = 0;
        while (!hit && cyc < 200) begin
            @(negedge clk); cyc++;
            if (out_valid && out_index == 5'd20) begin
                hit = 1;
                reset = 1'b1;
            end
        end
        @(negedge clk);
        vectors++;
        if (!hit || {rd_index, out_valid, out_index, out_data, out_last, busy, done, checksum} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got hit=%0b v=%0b idx=%0d data=%h last=%0b busy=%0b done=%0b cs=%h, expected all 0",
                     hit, out_valid, out_index, out_data, out_last, busy, done, checksum);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (done_count != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_no_done: got pulses=%0d busy=%0b, expected 0 0", done_count, busy);
        end
        push_full();
        pulse_start();
        vectors++;
        if (rd_index !== 5'd0) begin
            miscompares++;
            $display("FAIL rst_mid_restart: got rd=%0d, expected 0", rd_index);
        end
        cyc = 1; seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            if (done) seen = 1;
        end
        vectors++;
        if (!seen || cyc != 65 || exp_q.size() != 0 || checksum !== exp_csum) begin
            miscompares++;
            $display("FAIL rst_mid_fresh: got seen=%0b cycle=%0d left=%0d cs=%h, expected 1 65 0 cs=%h",
                     seen, cyc, exp_q.size(), checksum, exp_csum);
        end
        @(negedge clk);
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_gating();
        test_abort();
        test_param_range();
        test_reset_mid_dump();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Read-side companion to the CPU register file: once the core has halted, it walks a contiguous range of architectural registers through one register-file read port. Each register is emitted as an {index, data} beat on a valid/ready stream, with an XOR checksum and completion flags. It sits beside the register file in the CPU top level, replacing simulation-only register printing with a synthesizable dump path for testbench and debug-UART consumers.

## Interface
Parameters:
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle request to begin a dump; accepted only in IDLE with halted=1.
- halted  input  1  CPU halted; read port is owned by this block only while high.
- rd_index  output  5  register-file read-port index.
- rd_data  input  32  register-file read-port data (combinational from rd_index).
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer ready.
- out_index  output  5  register index of current beat.
- out_data  output  32  register value of current beat.
- out_last  output  1  current beat is LAST_REG.
- busy  output  1  dump in progress (state != IDLE and != DONE).
- done  output  1  one-cycle pulse after final beat accepted.
- checksum  output  32  XOR of all out_data values accepted in the current or most recent dump.

## Operation
- States: IDLE, READ, OUT, DONE.
- IDLE: rd_index=0, out_valid=0. If start=1 and halted=1, then: cur=FIRST_REG, checksum<=0, and the next state is READ. Otherwise start is ignored.
- READ (one cycle): rd_index=cur. Register out_data<=rd_data, out_index<=cur, out_last<=(cur==LAST_REG). Next state is OUT.
- OUT: out_valid=1. Beat fields stay stable until the handshake.
  - On out_valid&&out_ready: checksum<=checksum^out_data.
  - If out_last, go to DONE. Otherwise cur<=cur+1 and go to READ.
- DONE (one cycle): done=1, then return to IDLE. checksum holds until the next accepted start.
- Abort: halted=0 in READ or OUT forces IDLE on the next edge.
  - out_valid drops. This is the only permitted valid withdrawal.
  - done is not pulsed. checksum holds its partial value.
- start while busy or in DONE is ignored.
- Register 0 is dumped as whatever rd_data returns (the register file supplies 0). No special casing here.
- cur is 5 bits. It never increments past LAST_REG, so there is no wrap.

## Timing
- Reset value of every output is 0: rd_index, out_valid, out_index, out_data, out_last, busy, done, checksum. State returns to IDLE.
- Reset mid-dump takes effect at the next edge with the same values; no done pulse is produced.
- Latency: start edge, then 1 cycle READ, then out_valid high on the 2nd edge after start.
- Throughput: 2 cycles per register with out_ready held high. The full default dump takes 64 cycles from READ entry to the last handshake, and done follows on the next cycle.
- Back-pressure: OUT holds indefinitely while out_ready=0, with no change to any beat field.
- busy is high in READ and OUT only.

## Structure
- The shared CPU package holds the state typedef (IDLE, READ, OUT, DONE) and REG_INDEX_W=5.
- The CPU top muxes the register file's port A index between decode and this block using halted.
- Single module; no sub-module is needed. The beat register is inline.

## Test plan
- Full dump, ready held high: regs[i]=32'h1000_0000+i.
  - Expect 32 beats, index 0..31 in order; beat 0 data=0.
  - out_last only on index 31; done pulses once.
  - checksum = XOR of the 31 non-zero values.
- Back-pressure: out_ready low for 5 cycles during the beat for index 7.
  - out_valid stays high; out_index=7 and out_data=32'h1000_0007 stay stable.
  - No duplicate or skipped beat.
- Start gating:
  - start with halted=0 leaves busy=0 and out_valid=0.
  - A second start during a dump does not restart it; cur continues monotonically.
- Abort: drop halted during the beat for index 12.
  - Next cycle the block is in IDLE with out_valid=0 and no done.
  - checksum = XOR of beats 0..11.
- Parameterised range FIRST_REG=2, LAST_REG=3, regs[2]=32'hDEAD_BEEF, regs[3]=32'h0000_FFFF.
  - Expect 2 beats; out_last on index 3.
  - checksum=32'hDEAD_4110.
- Reset mid-dump at index 20: all outputs read 0 the following cycle, and a fresh start dumps from FIRST_REG.
